// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: WIDTH-bit register with load/clear and multi-step shift/rotate under a busy/done handshake
module shift_reg_ctrl #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;

    logic [0:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d, step_val;
    logic             sout_q, sout_d, step_sout, done_q, done_d, multi;

    // one step of the latched shift/rotate op applied to the current contents
    always_comb begin
        step_val  = q_q;
        step_sout = sout_q;
        case (op_q)
            OP_SHL: begin step_val = {q_q[WIDTH-2:0], sin};      step_sout = q_q[WIDTH-1]; end
            OP_SHR: begin step_val = {sin, q_q[WIDTH-1:1]};      step_sout = q_q[0];       end
            OP_ROL: begin step_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; step_sout = q_q[WIDTH-1]; end
            OP_ROR: begin step_val = {q_q[0], q_q[WIDTH-1:1]};   step_sout = q_q[0];       end
            default: ;
        endcase
    end

    // command acceptance in IDLE, step sequencing and completion in RUN
    always_comb begin
        multi   = (op >= OP_SHL) && (op <= OP_ROR) && (amt != '0);
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                op_d = op;
                if (multi) begin
                    state_d = RUN;
                    cnt_d   = amt;
                end else begin
                    done_d = 1'b1;
                    q_d    = (op == OP_LOAD) ? din : (op == OP_CLEAR) ? '0 : q_q;
                end
            end
        end else begin
            q_d    = step_val;
            sout_d = step_sout;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == AMT_W'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    // state registers; reset abandons any command in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign q    = q_q;
    assign sout = sout_q;
    assign busy = (state_q == RUN);
    assign done = done_q;
endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb_shift_reg_ctrl: randomized and directed checks of shift_reg_ctrl against an arithmetic reference model
module tb_shift_reg_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, sin = 1'b0;
    logic [2:0] op = '0, amt = '0;
    logic [7:0] din = '0, q;
    logic       sout, busy, done;
    int n_tests = 0, n_fail = 0;
    int mq = 0, msout = 0;

    always #5 clk = ~clk;

    shift_reg_ctrl #(.WIDTH(8), .AMT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .amt(amt),
        .din(din), .sin(sin), .q(q), .sout(sout), .busy(busy), .done(done)
    );

    function automatic void mstep(input logic [2:0] o, input int s);
        case (o)
            3'd2: begin msout = (mq >> 7) & 1; mq = ((mq << 1) & 255) | s;        end
            3'd3: begin msout = mq & 1;        mq = (mq >> 1) | (s << 7);          end
            3'd4: begin msout = (mq >> 7) & 1; mq = ((mq << 1) & 255) | (mq >> 7); end
            3'd5: begin msout = mq & 1;        mq = (mq >> 1) | ((mq & 1) << 7);   end
            default: ;
        endcase
    endfunction

    task automatic run_cmd(input logic [2:0] o, input int k, input logic [7:0] d,
                           input logic [7:0] sins, input bit poke);
        bit multi;
        multi = (o >= 3'd2) && (o <= 3'd5) && (k > 0);
        start = 1'b1; op = o; amt = 3'(k); din = d;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); amt = 3'($urandom); din = 8'($urandom);
        if (!multi) begin
            if (o == 3'd1) mq = d;
            else if (o == 3'd6) mq = 0;
        end
        n_tests++;
        if (q !== mq[7:0] || sout !== msout[0] || busy !== multi || done !== !multi) begin
            n_fail++;
            $display("FAIL accept op=%0d k=%0d: got q=%h sout=%b busy=%b done=%b, want q=%h sout=%0d busy=%b done=%b",
                     o, k, q, sout, busy, done, mq[7:0], msout, multi, !multi);
        end
        if (multi) begin
            for (int i = 1; i <= k; i++) begin
                sin = sins[i-1];
                if (poke) begin start = 1'b1; op = 3'd1; din = 8'hFF; end
                @(posedge clk); #1;
                mstep(o, int'(sins[i-1]));
                n_tests++;
                if (q !== mq[7:0] || sout !== msout[0] || busy !== (i < k) || done !== (i == k)) begin
                    n_fail++;
                    $display("FAIL step%0d op=%0d k=%0d: got q=%h sout=%b busy=%b done=%b, want q=%h sout=%0d busy=%b done=%b",
                             i, o, k, q, sout, busy, done, mq[7:0], msout, i < k, i == k);
                end
            end
        end
        start = 1'b0; op = '0;
    endtask

    task automatic idle_tick();
        start = 1'b0; sin = 1'($urandom);
        @(posedge clk); #1;
        n_tests++;
        if (q !== mq[7:0] || sout !== msout[0] || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle: got q=%h sout=%b busy=%b done=%b, want q=%h sout=%0d busy=0 done=0",
                     q, sout, busy, done, mq[7:0], msout);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_tests++;
        if (q !== 8'h00 || sout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: got q=%h sout=%b busy=%b done=%b, want all 0", q, sout, busy, done);
        end
        run_cmd(3'd1, 0, 8'hA5, 8'h00, 1'b0);
        run_cmd(3'd4, 1, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; mq = 0; msout = 0;
        n_tests++;
        if (q !== 8'h00 || sout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got q=%h sout=%b busy=%b done=%b, want all 0", q, sout, busy, done);
        end
        run_cmd(3'd1, 0, 8'hA5, 8'h00, 1'b0);
        start = 1'b1; op = 3'd4; amt = 3'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; mq = 0; msout = 0;
        n_tests++;
        if (q !== 8'h00 || sout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_run: got q=%h sout=%b busy=%b done=%b, want all 0", q, sout, busy, done);
        end
        repeat (6) idle_tick();
    endtask

    task automatic test_load_clear();
        run_cmd(3'd1, 0, 8'h3C, 8'h00, 1'b0);
        n_tests++;
        if (q !== 8'h3C) begin n_fail++; $display("FAIL load: got q=%h want 3c", q); end
        idle_tick();
        run_cmd(3'd6, 0, 8'h77, 8'h00, 1'b0);
        n_tests++;
        if (q !== 8'h00) begin n_fail++; $display("FAIL clear: got q=%h want 00", q); end
        idle_tick();
    endtask

    task automatic test_rol();
        run_cmd(3'd1, 0, 8'h81, 8'h00, 1'b0);
        run_cmd(3'd4, 3, 8'h00, 8'h00, 1'b0);
        n_tests++;
        if (q !== 8'h0C || sout !== 1'b0) begin
            n_fail++; $display("FAIL rol3: got q=%h sout=%b want q=0c sout=0", q, sout);
        end
        idle_tick();
    endtask

    task automatic test_shr();
        run_cmd(3'd1, 0, 8'hF0, 8'h00, 1'b0);
        run_cmd(3'd3, 4, 8'h00, 8'h05, 1'b0);
        n_tests++;
        if (q !== 8'h5F || sout !== 1'b0) begin
            n_fail++; $display("FAIL shr4: got q=%h sout=%b want q=5f sout=0", q, sout);
        end
        run_cmd(3'd2, 0, 8'h00, 8'hFF, 1'b0);
        n_tests++;
        if (q !== 8'h5F) begin n_fail++; $display("FAIL shl0: got q=%h want 5f", q); end
        idle_tick();
    endtask

    task automatic test_busy_ignore();
        logic [7:0] v;
        v = 8'($urandom);
        run_cmd(3'd1, 0, v, 8'h00, 1'b0);
        run_cmd(3'd5, 7, 8'h00, 8'h00, 1'b1);
        n_tests++;
        if (q !== {v[6:0], v[7]}) begin
            n_fail++; $display("FAIL ror7: got q=%h want %h", q, {v[6:0], v[7]});
        end
        run_cmd(3'd1, 0, 8'h96, 8'h00, 1'b0);
        n_tests++;
        if (q !== 8'h96) begin n_fail++; $display("FAIL load_in_done: got q=%h want 96", q); end
        idle_tick();
    endtask

    task automatic test_back_to_back();
        run_cmd(3'd1, 0, 8'h5A, 8'h00, 1'b0);
        run_cmd(3'd4, 7, 8'h00, 8'h00, 1'b0);
        run_cmd(3'd4, 1, 8'h00, 8'h00, 1'b0);
        n_tests++;
        if (q !== 8'h5A) begin n_fail++; $display("FAIL b2b_rol: got q=%h want 5a", q); end
        idle_tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            run_cmd(3'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) idle_tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_clear();
        test_rol();
        test_shr();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_reg_ctrl.md
Name: shift_reg_ctrl

Overview:
Parametrised register with a command port, generalising the single-bit D flip-flop into a WIDTH-bit storage element. Supported operations are parallel load, clear, multi-step logical shift and multi-step rotate.
Multi-step operations run one bit-position per clock under a small controller. A busy/done handshake lets a front-end FSM (button handler, UART byte builder, LED pattern engine) sequence commands.
Used on STEPFPGA designs wherever a plain D register needs load/shift/rotate modes.

Parameters:
WIDTH, 8, register width in bits (>=2)
AMT_W, 3, width of the shift/rotate amount field; max steps per command = 2**AMT_W-1

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk edge
start  input  1  command strobe; accepted only when busy=0
op  input  3  command code, sampled on accepting edge
amt  input  AMT_W  step count for shift/rotate, sampled on accepting edge
din  input  WIDTH  parallel load data
sin  input  1  serial input bit for SHL/SHR, sampled on every shifting edge
q  output  WIDTH  register contents (registered)
sout  output  1  last bit shifted/rotated out (registered)
busy  output  1  high while a multi-step command is executing
done  output  1  one-cycle pulse on command completion

Behaviour:
- Reset (rst_n=0 at rising edge) forces q=0, sout=0, busy=0, done=0, step counter=0, state=IDLE. Applies mid-operation: the command in progress is abandoned, not resumed, and done does not pulse.
- Op codes:
  - 000 NOP
  - 001 LOAD: q<=din
  - 010 SHL: q<={q[W-2:0],sin}, sout<=q[W-1]
  - 011 SHR: q<={sin,q[W-1:1]}, sout<=q[0]
  - 100 ROL: q<={q[W-2:0],q[W-1]}, sout<=q[W-1]
  - 101 ROR: q<={q[0],q[W-1:1]}, sout<=q[0]
  - 110 CLEAR: q<=0
  - 111 reserved, behaves as NOP
- States: IDLE, RUN.
- IDLE, start=1: command accepted on edge E0; op and amt are latched.
  - NOP/LOAD/CLEAR/reserved, or any shift/rotate with amt=0: q updated at E0 (unchanged for NOP/reserved/amt=0). done=1 the following cycle. busy stays 0. State stays IDLE.
  - Shift/rotate with amt=k>0: at E0 no data change; busy<=1, counter<=k, state<=RUN.
- RUN: each edge performs one step of the latched op and decrements counter.
  - On the edge where counter==1: final step, busy<=0, done<=1, state<=IDLE.
  - Latency: k steps occur on edges E1..Ek. busy high for exactly k cycles. done high for the one cycle after Ek.
- start while busy=1: ignored, not queued. op/amt/din changes during RUN have no effect. sin is live and sampled per step.
- done is high for exactly one cycle per accepted command. A new start may be accepted in the same cycle done is high (busy=0), giving back-to-back commands with no idle gap.
- sout holds its value when no step occurs. LOAD/CLEAR/NOP do not change sout.
- Wrap-around: rotate by k=WIDTH returns q to its original value. Logical shift by k>=WIDTH leaves q filled entirely with sampled sin bits.
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: load 8'hA5, then rst_n=0 for 1 edge -> q=8'h00, sout=0, busy=0, done=0. Repeat with reset asserted during a 5-step ROL -> same values, no done pulse.
- LOAD din=8'h3C with start=1 for one cycle -> q=8'h3C the next cycle, done=1 for 1 cycle, busy never 1. CLEAR afterwards -> q=8'h00.
- q=8'h81, ROL amt=3 -> busy=1 for 3 cycles; q goes 8'h03, 8'h06, 8'h0C; sout ends 0; done pulses once on the cycle after the third step.
- q=8'hF0, SHR amt=4, sin=1,0,1,0 on successive steps -> q=8'h5F, sout=0. SHL amt=0 -> q unchanged, done next cycle.
- During a 7-step ROR, start=1 with op=LOAD din=8'hFF -> ignored, q ends as ROR7 of the original value. A LOAD issued in the done cycle is accepted, and q=din on the next cycle.
- q=8'h5A, ROL amt=7 then ROL amt=1 back-to-back -> q=8'h5A, two done pulses separated by 1 cycle.
